// File: rtl/up_time_cnt_pkg.sv
// Shared definitions for the MM:SS time counters: run-control state
// encoding and default digit moduli. The display mux and the countdown
// timer use the same constants.
package up_time_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int DIGIT_MOD_UNITS = 10;
  localparam int SEC_T_MOD_DEF   = 6;
  localparam int MIN_T_MOD_DEF   = 10;
  localparam int DIGIT_BITS_DEF  = 4;

  // Highest legal value of a modulo-N digit
  function automatic int mod_max(input int modulo);
    return modulo - 1;
  endfunction

endpackage

// File: rtl/up_time_cnt_cnt.sv
// up_cnt: generic modulo-MOD up counter digit with carry in/out.
// CE advances the digit and wraps it to 0 after MOD-1. CEO is high when CE
// arrives while the digit sits at MOD-1.
// HOLD blocks the register update but leaves CEO alone. This lets the
// parent freeze the whole chain on the terminal tick while still seeing
// the carry out of the top digit.
// CLR is a synchronous clear and takes priority over counting.
module up_cnt
  import up_time_cnt_pkg::*;
#(
  parameter int MOD   = DIGIT_MOD_UNITS,
  parameter int WIDTH = DIGIT_BITS_DEF
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             CE,
  input  logic             HOLD,
  output logic [WIDTH-1:0] Q,
  output logic             CEO
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(mod_max(MOD));
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count;
  logic             at_last;

  assign at_last = (count == LAST);
  assign CEO     = CE & at_last;
  assign Q       = count;

  // Digit register: clear wins, then wrap or increment on enable
  always_ff @(posedge CLK) begin
    if (CLR) begin
      count <= '0;
    end else if (CE && !HOLD) begin
      if (at_last) begin
        count <= '0;
      end else begin
        count <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/up_time_cnt.sv
// up_time_cnt: count-up MM:SS stopwatch.
// Four cascaded up_cnt digits advance on the 1 Hz CE tick while the
// run-control FSM is in RUN. START, STOP and ZERO are single-cycle pulses.
// Build option UP_TIME_CNT_WRAP_EN: when it is defined, the terminal tick
// wraps the digits to 00:00 and the counter keeps running. When it is
// undefined, the digits hold at maximum and the FSM enters DONE.
module up_time_cnt
  import up_time_cnt_pkg::*;
#(
  parameter int MIN_T_MOD  = MIN_T_MOD_DEF,
  parameter int SEC_T_MOD  = SEC_T_MOD_DEF,
  parameter int DIGIT_BITS = DIGIT_BITS_DEF
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  CE,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  ZERO,
  output logic [DIGIT_BITS-1:0] SEC_U,
  output logic [DIGIT_BITS-1:0] SEC_T,
  output logic [DIGIT_BITS-1:0] MIN_U,
  output logic [DIGIT_BITS-1:0] MIN_T,
  output logic                  RUNNING,
  output logic                  DONE,
  output logic                  CEO
);

  state_t state;
  state_t state_next;

  logic en;
  logic clr_digits;
  logic hold;
  logic terminal;
  logic co_su;
  logic co_st;
  logic co_mu;
  logic co_mt;

  // Counting depends on the registered state, so a CE in the same cycle as
  // START is ignored and a CE in the same cycle as STOP still counts
  assign en         = (state == ST_RUN) & CE;
  assign clr_digits = CLR | ZERO;

  // The carry out of the top digit is exactly en & (all digits at max)
  assign terminal = co_mt;
  assign CEO      = terminal;

`ifdef UP_TIME_CNT_WRAP_EN
  assign hold = 1'b0;
`else
  assign hold = terminal;
`endif

  up_cnt #(.MOD(DIGIT_MOD_UNITS), .WIDTH(DIGIT_BITS)) u_sec_u (
    .CLK(CLK), .CLR(clr_digits), .CE(en), .HOLD(hold), .Q(SEC_U), .CEO(co_su)
  );

  up_cnt #(.MOD(SEC_T_MOD), .WIDTH(DIGIT_BITS)) u_sec_t (
    .CLK(CLK), .CLR(clr_digits), .CE(co_su), .HOLD(hold), .Q(SEC_T), .CEO(co_st)
  );

  up_cnt #(.MOD(DIGIT_MOD_UNITS), .WIDTH(DIGIT_BITS)) u_min_u (
    .CLK(CLK), .CLR(clr_digits), .CE(co_st), .HOLD(hold), .Q(MIN_U), .CEO(co_mu)
  );

  up_cnt #(.MOD(MIN_T_MOD), .WIDTH(DIGIT_BITS)) u_min_t (
    .CLK(CLK), .CLR(clr_digits), .CE(co_mu), .HOLD(hold), .Q(MIN_T), .CEO(co_mt)
  );

  // Run-control state register with synchronous reset
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and status flags; ZERO beats STOP, and STOP beats START
  always_comb begin
    state_next = state;
    RUNNING    = 1'b0;
    DONE       = 1'b0;
    if (ZERO) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!STOP && START) state_next = ST_RUN;
        end
        ST_RUN: begin
`ifdef UP_TIME_CNT_WRAP_EN
          if (STOP) state_next = ST_PAUSED;
`else
          if (terminal) state_next = ST_DONE;
          else if (STOP) state_next = ST_PAUSED;
`endif
        end
        ST_PAUSED: begin
          if (!STOP && START) state_next = ST_RUN;
        end
        ST_DONE: begin
          state_next = ST_DONE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
    RUNNING = (state == ST_RUN);
`ifdef UP_TIME_CNT_WRAP_EN
    DONE = 1'b0;
`else
    DONE = (state == ST_DONE);
`endif
  end

endmodule

// File: tb/tb_up_time_cnt.sv
// Testbench for up_time_cnt: the default instance (99:59) and a 59:59
// instance with MIN_T_MOD=6 share stimulus. Expected values are queued
// when stimulus is issued. A negedge monitor pops and compares them.
module tb_up_time_cnt;

  typedef struct packed {
    logic       which;
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
    logic       run;
    logic       dn;
    logic       co;
  } expect_t;

  logic clk   = 1'b0;
  logic clr   = 1'b1;
  logic ce    = 1'b0;
  logic start = 1'b0;
  logic stop  = 1'b0;
  logic zero  = 1'b0;

  logic [3:0] secU, secT, minU, minT;
  logic       running, done, ceo;
  logic [3:0] secU6, secT6, minU6, minT6;
  logic       running6, done6, ceo6;

  expect_t expQ[$];
  string   nameQ[$];
  expect_t monExp;
  expect_t monAct;
  string   monName;
  int      checks = 0;
  int      errors = 0;

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  up_time_cnt dut (
    .CLK(clk), .CLR(clr), .CE(ce), .START(start), .STOP(stop), .ZERO(zero),
    .SEC_U(secU), .SEC_T(secT), .MIN_U(minU), .MIN_T(minT),
    .RUNNING(running), .DONE(done), .CEO(ceo)
  );

  up_time_cnt #(.MIN_T_MOD(6), .SEC_T_MOD(6), .DIGIT_BITS(4)) dut6 (
    .CLK(clk), .CLR(clr), .CE(ce), .START(start), .STOP(stop), .ZERO(zero),
    .SEC_U(secU6), .SEC_T(secT6), .MIN_U(minU6), .MIN_T(minT6),
    .RUNNING(running6), .DONE(done6), .CEO(ceo6)
  );

  // Monitor: compare everything queued for this cycle, plus digit legality
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      monExp  = expQ.pop_front();
      monName = nameQ.pop_front();
      if (monExp.which) monAct = {1'b1, minT6, minU6, secT6, secU6, running6, done6, ceo6};
      else              monAct = {1'b0, minT, minU, secT, secU, running, done, ceo};
      checks++;
      if (monAct !== monExp) begin
        errors++;
        $display("[TB] FAIL %s: actual %0d%0d:%0d%0d run=%b done=%b ceo=%b, expected %0d%0d:%0d%0d run=%b done=%b ceo=%b",
                 monName, monAct.mt, monAct.mu, monAct.st, monAct.su, monAct.run, monAct.dn, monAct.co,
                 monExp.mt, monExp.mu, monExp.st, monExp.su, monExp.run, monExp.dn, monExp.co);
      end
    end
    checks++;
    if (secU > 4'd9 || secT > 4'd5 || minU > 4'd9 || minT > 4'd9 ||
        secU6 > 4'd9 || secT6 > 4'd5 || minU6 > 4'd9 || minT6 > 4'd5) begin
      errors++;
      $display("[TB] FAIL digit_range: actual dut %0d%0d:%0d%0d dut6 %0d%0d:%0d%0d, expected digits within modulo",
               minT, minU, secT, secU, minT6, minU6, secT6, secU6);
    end
  end

  // Watchdog so the bench always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual timeout, expected stimulus to complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic c, input logic s, input logic p,
                               input logic z, input logic r);
    ce = c; start = s; stop = p; zero = z; clr = r;
  endtask

  // Queue the outputs expected at this cycle's negedge
  task automatic checkOutput(input string n, input logic w, input int mt, input int mu,
                             input int st, input int su, input logic run,
                             input logic dn, input logic co);
    expect_t e;
    e.which = w;
    e.mt = 4'(mt); e.mu = 4'(mu); e.st = 4'(st); e.su = 4'(su);
    e.run = run; e.dn = dn; e.co = co;
    expQ.push_back(e);
    nameQ.push_back(n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    step();
    // Reset
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset6", 1, 0, 0, 0, 0, 0, 0, 0);
    step();

    // START with coincident CE, then 61 counted ticks, the last one with STOP
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("start_ce", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("run_entered", 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    runTicks(60);
    applyStimulus(1, 0, 1, 0, 0);
    checkOutput("stop_ce_mid", 0, 0, 1, 0, 0, 1, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("count_61", 0, 0, 1, 0, 1, 0, 0, 0);
    step();

    // Resume to 12:34 then CLR held three cycles with CE asserted
    applyStimulus(0, 1, 0, 0, 0);
    step();
    runTicks(693);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("at_12_34", 0, 1, 2, 3, 4, 1, 0, 0);
    step();
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("clr_pre_edge", 0, 1, 2, 3, 4, 1, 0, 0);
    step();
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("clr_first_edge", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("clr_held", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("clr_released", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("idle_no_count", 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Pause at 00:05, ignore ten ticks, resume for one tick
    applyStimulus(0, 1, 0, 0, 0);
    step();
    runTicks(5);
    applyStimulus(0, 0, 1, 0, 0);
    step();
    runTicks(10);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("paused_hold", 0, 0, 0, 0, 5, 0, 0, 0);
    step();
    applyStimulus(0, 1, 0, 0, 0);
    step();
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("resume_run", 0, 0, 0, 0, 5, 1, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("resume_tick", 0, 0, 0, 0, 6, 1, 0, 0);
    step();

    // START+STOP from RUN pauses; from IDLE stays idle; ZERO+START clears
    applyStimulus(0, 1, 1, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("startstop_run", 0, 0, 0, 0, 6, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 1, 0);
    step();
    applyStimulus(0, 1, 1, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("startstop_idle", 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    applyStimulus(0, 1, 0, 0, 0);
    step();
    runTicks(3);
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("zero_start_mid", 0, 0, 0, 0, 3, 1, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("zero_start", 0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Terminal at 99:59
    applyStimulus(0, 1, 0, 0, 0);
    step();
    runTicks(5998);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("at_99_58", 0, 9, 9, 5, 8, 1, 0, 0);
    step();
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("terminal_ceo", 0, 9, 9, 5, 9, 1, 0, 1);
    step();
`ifdef UP_TIME_CNT_WRAP_EN
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("wrap_zero", 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("wrap_keeps_run", 0, 0, 0, 0, 0, 1, 0, 0);
    step();
`else
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("done_hold", 0, 9, 9, 5, 9, 0, 1, 0);
    step();
    applyStimulus(0, 1, 0, 0, 0);
    step();
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("done_ignores_start", 0, 9, 9, 5, 9, 0, 1, 0);
    step();
`endif
    applyStimulus(0, 0, 0, 1, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("zero_after_terminal", 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("zero_after_terminal6", 1, 0, 0, 0, 0, 0, 0, 0);
    step();

    // 59:59 build terminal, default build rolls into 60:00
    applyStimulus(0, 1, 0, 0, 0);
    step();
    runTicks(3598);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("g_at_59_58", 0, 5, 9, 5, 8, 1, 0, 0);
    checkOutput("g6_at_59_58", 1, 5, 9, 5, 8, 1, 0, 0);
    step();
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("g_at_59_59", 0, 5, 9, 5, 9, 1, 0, 0);
    checkOutput("g6_terminal_ceo", 1, 5, 9, 5, 9, 1, 0, 1);
    step();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("g_rolls_60_00", 0, 6, 0, 0, 0, 1, 0, 0);
`ifdef UP_TIME_CNT_WRAP_EN
    checkOutput("g6_wrap", 1, 0, 0, 0, 0, 1, 0, 0);
`else
    checkOutput("g6_done_hold", 1, 5, 9, 5, 9, 0, 1, 0);
`endif
    step();

    step();
    step();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: actual %0d pending, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/up_time_cnt.md
Name: up_time_cnt

Overview:
- Count-up (stopwatch) MM:SS time counter. It is the counting-direction counterpart of the countdown timer's cascaded down-counter chain.
- Four cascaded modulo up-counter digits (MIN_T, MIN_U, SEC_T, SEC_U) advance on a 1 Hz clock-enable tick.
- Gated by a small run-control FSM driven by single-cycle button pulses.
- Outputs are BCD digits for the shared display mux and status flags for the top-level mode controller.

Parameters:
- MIN_T_MOD, 10, modulo of minutes-tens digit (max minutes = MIN_T_MOD*10-1)
- SEC_T_MOD, 6, modulo of seconds-tens digit
- DIGIT_BITS, 4, width of each BCD digit output

Ports:
- CLK  in  1  system clock
- CLR  in  1  synchronous active-high reset
- CE  in  1  1 Hz tick, single-cycle pulse
- START  in  1  debounced single-cycle start/resume pulse
- STOP  in  1  debounced single-cycle pause pulse
- ZERO  in  1  single-cycle clear-to-00:00 pulse
- SEC_U  out  DIGIT_BITS  seconds units, 0..9
- SEC_T  out  DIGIT_BITS  seconds tens, 0..SEC_T_MOD-1
- MIN_U  out  DIGIT_BITS  minutes units, 0..9
- MIN_T  out  DIGIT_BITS  minutes tens, 0..MIN_T_MOD-1
- RUNNING  out  1  high while state==RUN
- DONE  out  1  high while state==DONE
- CEO  out  1  combinational carry-out of the most significant digit

Behaviour:
- Reset: CLR is sampled on the rising edge of CLK only. It sets all digits to 0 and the state to IDLE, with RUNNING=0, DONE=0 and CEO=0. CLR overrides all other inputs.
- FSM states: IDLE, RUN, PAUSED, DONE, held in one registered state variable.
  - IDLE --START--> RUN
  - RUN --STOP--> PAUSED
  - PAUSED --START--> RUN
  - RUN --terminal tick--> DONE
  - any state --ZERO--> IDLE, digits cleared to 0 on the same edge
  - DONE ignores START and STOP; only ZERO or CLR leave DONE.
- Input priority within one cycle: CLR > ZERO > STOP > START. When START and STOP are both asserted, STOP wins, so RUN goes to PAUSED and IDLE/PAUSED hold.
- Count enable: en = (state==RUN) & CE, using the registered state.
  - A CE arriving in the same cycle as START is not counted. Counting begins at the first CE after RUN is entered.
  - A CE arriving in the same cycle as STOP is counted, because the state is still RUN.
- Cascade: each digit increments when its enable is high. It wraps to 0 after modulo-1 and passes enable to the next digit in the same cycle. Chain order: SEC_U -> SEC_T -> MIN_U -> MIN_T. All digits update on one edge; there is no ripple latency.
- Terminal value: all digits at max (default 99:59).
- CEO = en & all digits at max. It is combinational and lasts one cycle.
- Digits never hold illegal values. Increments use DIGIT_BITS unsigned arithmetic compared against the modulo-1 constant.
- The ZERO clear takes effect on the next edge. A ZERO arriving together with a CE does not count that tick.

Optional Feature:
- Macro: UP_TIME_CNT_WRAP_EN.
- Defined: the terminal tick wraps all digits to 00:00. The state stays RUN and CEO pulses. DONE is tied to 0 and the DONE state is unreachable.
- Undefined (default): on the terminal tick the digits hold at max and the state goes to DONE. DONE=1 and RUNNING=0 from the next cycle. CEO still pulses for that one cycle.

Decomposition:
- Shared package holds:
  - state encoding typedef/localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSED=2'd2, ST_DONE=2'd3)
  - DIGIT_MOD_UNITS=10
  - default SEC_T_MOD, MIN_T_MOD constants, shared with the display and countdown blocks
- One sub-module, up_cnt: a generic modulo-N up counter with CE/CEO and a synchronous clear, instantiated four times. The top level holds the FSM, the enable chain and the terminal handling.

Test Plan:
- CLR held 3 cycles mid-count at 12:34 -> digits 00:00, RUNNING=0, DONE=0 on the first edge after CLR.
- START, then 61 CE ticks -> display reads 01:01. A CE coincident with START is not counted; a CE coincident with STOP is counted and the state goes to PAUSED.
- PAUSED at 00:05 with 10 CE ticks -> digits unchanged. START, then 1 CE -> 00:06.
- Reach 99:58 in RUN; CE -> 99:59; next CE -> CEO high for exactly 1 cycle.
  - Default build: digits hold 99:59, DONE=1, START is ignored, ZERO -> 00:00 and IDLE.
  - UP_TIME_CNT_WRAP_EN build: digits go to 00:00, RUNNING stays 1.
- START+STOP in the same cycle from IDLE -> stays IDLE. From RUN -> PAUSED. ZERO+START in the same cycle -> IDLE, 00:00.
- Parameters SEC_T_MOD=6, MIN_T_MOD=6: run to 59:59 -> terminal behaviour as above. SEC_T never exceeds 5 and MIN_T never exceeds 5 (assertion across the whole run).
